// File: rtl/slider_pkg.sv
// Shared types and constants for the 2x4 slider puzzle command stage.
// A cell index is {row, col[1:0]}: row 0 is the top row, col runs 0..3.
package slider_pkg;

  localparam int POS_W      = 3;
  localparam int ROWS       = 2;
  localparam int COLS       = 4;
  localparam int BLANK_INIT = 7;

  // Direction the blank travels.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  // Generator FSM states, kept as plain constants for older tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

endpackage

// File: rtl/slider_move_gen_neighbor.sv
// Combinational neighbour lookup: given the blank cell and a direction,
// returns the cell the blank would move into and whether it stays on the board.
// Kept separate so a future scrambler/solver can reuse the same legality rules.
module slider_neighbor
  import slider_pkg::*;
(
  input  logic [POS_W-1:0] blank_pos,
  input  logic [1:0]       dir,
  output logic [POS_W-1:0] neighbor,
  output logic             legal
);

  logic       row;
  logic [1:0] col;

  assign row = blank_pos[2];
  assign col = blank_pos[1:0];

  // Edge checks and the neighbour index for each direction of travel.
  always_comb begin
    neighbor = blank_pos;
    legal    = 1'b0;
    case (dir_e'(dir))
      DIR_UP: begin
        legal    = row;
        neighbor = {1'b0, col};
      end
      DIR_DOWN: begin
        legal    = ~row;
        neighbor = {1'b1, col};
      end
      DIR_LEFT: begin
        legal    = (col != 2'd0);
        neighbor = {row, col - 2'd1};
      end
      DIR_RIGHT: begin
        legal    = (col != 2'd3);
        neighbor = {row, col + 2'd1};
      end
      default: begin
        legal    = 1'b0;
        neighbor = blank_pos;
      end
    endcase
  end

endmodule

// File: rtl/slider_move_gen.sv
// Command stage in front of the slider puzzle core. Accepts "move the blank"
// commands, tracks the blank, and issues from/to index pairs, holding off new
// commands long enough for the core's register and apply stages to finish.
// Every output is a flop; nothing on dir/dir_valid reaches an output directly.
module slider_move_gen
  import slider_pkg::*;
#(
  parameter int COUNT_W       = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int BLANK_INIT    = slider_pkg::BLANK_INIT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dir_valid,
  input  logic [1:0]         dir,
  output logic               dir_ready,
  output logic [POS_W-1:0]   from,
  output logic [POS_W-1:0]   to,
  output logic [POS_W-1:0]   blank_pos,
  output logic               illegal,
  output logic [COUNT_W-1:0] move_count
);

  // $clog2(SETTLE_CYCLES) bits hold 0..SETTLE_CYCLES-1, and SETTLE_CYCLES >= 2.
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [POS_W-1:0]    BLANK_RST   = POS_W'(BLANK_INIT);

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [POS_W-1:0]    neighbor;
  logic                legal;
  logic                handshake;

  slider_neighbor u_neighbor (
    .blank_pos (blank_pos),
    .dir       (dir),
    .neighbor  (neighbor),
    .legal     (legal)
  );

  assign handshake = dir_valid && dir_ready;

  // Command FSM: accept in IDLE, drive the move for one ISSUE cycle, then hold
  // the idle encoding (from == to) through SETTLE before accepting again.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      blank_pos  <= BLANK_RST;
      from       <= BLANK_RST;
      to         <= BLANK_RST;
      illegal    <= 1'b0;
      move_count <= '0;
      dir_ready  <= 1'b1;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (handshake) begin
            if (legal) begin
              state     <= ST_ISSUE;
              from      <= neighbor;
              to        <= blank_pos;
              blank_pos <= neighbor;
              dir_ready <= 1'b0;
              if (move_count != {COUNT_W{1'b1}}) begin
                move_count <= move_count + 1'b1;
              end
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state      <= ST_SETTLE;
          from       <= blank_pos;
          to         <= blank_pos;
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state     <= ST_IDLE;
            dir_ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          from      <= blank_pos;
          to        <= blank_pos;
          dir_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slider_move_gen.sv
// Bench for slider_move_gen: directed sequences followed by random commands,
// all compared every cycle against a row/column model of the puzzle board.
// A second instance built with a 2-bit counter shares the stimulus to
// exercise counter saturation.
module tb_slider_move_gen;

  localparam int SETTLE = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dir_valid = 1'b0;
  logic [1:0] dir = 2'd0;

  logic        dir_ready, illegal;
  logic [2:0]  from, to, blank_pos;
  logic [15:0] move_count;

  logic        s_dir_ready, s_illegal;
  logic [2:0]  s_from, s_to, s_blank_pos;
  logic [1:0]  s_move_count;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_blank, m_from, m_to, m_illegal, m_count, m_sat, m_busy;

  always #5 clock = ~clock;

  slider_move_gen #(.COUNT_W(16), .SETTLE_CYCLES(SETTLE), .BLANK_INIT(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .dir_ready  (dir_ready),
    .from       (from),
    .to         (to),
    .blank_pos  (blank_pos),
    .illegal    (illegal),
    .move_count (move_count)
  );

  slider_move_gen #(.COUNT_W(2), .SETTLE_CYCLES(SETTLE), .BLANK_INIT(7)) dut_sat (
    .clock      (clock),
    .reset      (reset),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .dir_ready  (s_dir_ready),
    .from       (s_from),
    .to         (s_to),
    .blank_pos  (s_blank_pos),
    .illegal    (s_illegal),
    .move_count (s_move_count)
  );

  // One clock edge of the model: board position as (row, col) arithmetic.
  function automatic void modelStep(input logic rst, input logic v, input logic [1:0] d);
    int row, col, nrow, ncol;
    bit ok;
    if (rst) begin
      m_blank = 7; m_from = 7; m_to = 7; m_illegal = 0;
      m_count = 0; m_sat = 0; m_busy = 0;
      return;
    end
    m_illegal = 0;
    if (m_busy > 0) begin
      m_busy = m_busy - 1;
      m_from = m_blank;
      m_to   = m_blank;
    end else if (v) begin
      row = m_blank / 4;
      col = m_blank % 4;
      nrow = row;
      ncol = col;
      case (d)
        2'd0: nrow = row - 1;
        2'd1: nrow = row + 1;
        2'd2: ncol = col - 1;
        default: ncol = col + 1;
      endcase
      ok = (nrow >= 0) && (nrow < 2) && (ncol >= 0) && (ncol < 4);
      if (ok) begin
        m_to    = m_blank;
        m_blank = nrow * 4 + ncol;
        m_from  = m_blank;
        if (m_count < 65535) m_count = m_count + 1;
        if (m_sat < 3) m_sat = m_sat + 1;
        m_busy = 1 + SETTLE;
      end else begin
        m_illegal = 1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("dir_ready",   32'(dir_ready),    32'(m_busy == 0));
    chk("from",        32'(from),         32'(m_from));
    chk("to",          32'(to),           32'(m_to));
    chk("blank_pos",   32'(blank_pos),    32'(m_blank));
    chk("illegal",     32'(illegal),      32'(m_illegal));
    chk("move_count",  32'(move_count),   32'(m_count));
    chk("sat_ready",   32'(s_dir_ready),  32'(m_busy == 0));
    chk("sat_from",    32'(s_from),       32'(m_from));
    chk("sat_to",      32'(s_to),         32'(m_to));
    chk("sat_count",   32'(s_move_count), 32'(m_sat));
  endtask

  // Drive one cycle's inputs at the falling edge, model the rising edge,
  // then check outputs at the next falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] d);
    reset     = rst;
    dir_valid = v;
    dir       = d;
    @(posedge clock);
    modelStep(rst, v, d);
    @(negedge clock);
    reset     = 1'b0;
    dir_valid = 1'b0;
    checkOutput();
  endtask

  // Hold a command valid until the generator is ready to take it.
  task automatic sendCmd(input logic [1:0] d);
    bit was_ready;
    for (int n = 0; n < 10; n++) begin
      was_ready = (m_busy == 0);
      applyStimulus(1'b0, 1'b1, d);
      if (was_ready) break;
    end
  endtask

  initial begin
    @(negedge clock);

    // Reset then idle.
    applyStimulus(1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 2'd0);

    // Single up move from reset, then let it settle.
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd0);
    chk("up_from_const", 32'(from), 32'd3);
    chk("up_to_const",   32'(to),   32'd7);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'd0);

    // Two illegal commands back to back from the start position.
    applyStimulus(1'b1, 1'b0, 2'd0);
    applyStimulus(1'b0, 1'b1, 2'd1);
    applyStimulus(1'b0, 1'b1, 2'd3);
    applyStimulus(1'b0, 1'b0, 2'd0);

    // Walk the blank to the top-left corner, final left is off the board.
    applyStimulus(1'b1, 1'b0, 2'd0);
    sendCmd(2'd0);
    sendCmd(2'd2);
    sendCmd(2'd2);
    sendCmd(2'd2);
    sendCmd(2'd2);
    sendCmd(2'd2);
    chk("corner_blank", 32'(blank_pos), 32'd0);
    // Fifth legal move: small counter stays pinned at its maximum.
    sendCmd(2'd3);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'd0);

    // Reset while in SETTLE.
    applyStimulus(1'b1, 1'b0, 2'd0);
    sendCmd(2'd0);
    applyStimulus(1'b0, 1'b0, 2'd0);
    applyStimulus(1'b1, 1'b0, 2'd0);

    // Random commands with occasional resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 2) != 0),
                    2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
